// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: halt opcode,
// default-width queue entry layout and the halt-detect helper.
package fetch_pkg;

    localparam int unsigned OPC_W       = 4;
    localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;

    localparam int unsigned DEF_INSTR_W = 16;
    localparam int unsigned DEF_ADDR_W  = 16;

    // Entry layout for the default widths; parameterised users build the
    // same {instr, pc} layout with their own widths.
    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fq_entry_t;

    // True when the opcode field (top OPC_W bits of an instruction) is a halt.
    function automatic logic is_halt(input logic [OPC_W-1:0] opcode);
        return opcode == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_queue_ring.sv
// fq_ring: generic DEPTH x WIDTH ring buffer with push, pop, clear,
// occupancy count and a combinational head read. DEPTH must be a power of two.
module fq_ring #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointer and occupancy values; clear wins over push/pop.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are live.
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer. Owns the fetch PC, keeps at most
// one request outstanding to a variable-latency instruction memory, queues
// returned instructions with their PCs, handles redirect/flush and halt.
// Optional: define FETCH_BYPASS_EN to forward a response straight to the
// output when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned        INSTR_W  = 16,
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [ADDR_W-1:0]  req_addr,
    input  logic               rsp_valid,
    input  logic [INSTR_W-1:0] rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_halted
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q, drop_d;
    logic              halted_q, halted_d;

    logic [CNT_W-1:0]  count;
    logic              queue_nonempty;
    entry_t            head, push_entry;
    logic              accept, rsp_fire, rsp_take, bypass, ring_push, ring_pop;

    assign queue_nonempty = (count != '0);

    // A request may only go out with no request in flight and space to land it.
    assign req_valid = ~rst & ~redirect & ~halted_q & ~outstanding_q & (count < CNT_W'(DEPTH));
    assign req_addr  = fpc_q;
    assign accept    = req_valid & req_ready;

    // Responses count only while a request is outstanding; a redirect or a
    // pending drop discards them.
    assign rsp_fire = rsp_valid & outstanding_q;
    assign rsp_take = rsp_fire & ~drop_q & ~redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_take & ~queue_nonempty;
`else
    assign bypass = 1'b0;
`endif

    assign push_entry.instr = rsp_data;
    assign push_entry.pc    = inflight_pc_q;
    assign ring_push        = rsp_take & ~(bypass & instr_ready);
    assign ring_pop         = queue_nonempty & instr_ready & ~redirect;

    fq_ring #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .clear_i (redirect),
        .push_i  (ring_push),
        .pop_i   (ring_pop),
        .data_i  (push_entry),
        .head_o  (head),
        .count_o (count)
    );

    // Fetch control next state: redirect overrides issue and response handling.
    always_comb begin
        fpc_d         = fpc_q;
        inflight_pc_d = inflight_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        halted_d      = halted_q;
        if (redirect) begin
            fpc_d    = redirect_pc;
            halted_d = 1'b0;
            if (outstanding_q) begin
                // Still waiting on memory: remember to discard what comes back.
                outstanding_d = ~rsp_valid;
                drop_d        = ~rsp_valid;
            end
        end else begin
            if (accept) begin
                outstanding_d = 1'b1;
                inflight_pc_d = fpc_q;
                fpc_d         = fpc_q + ADDR_W'(PC_STEP);
            end
            if (rsp_fire) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
                if (rsp_take && is_halt(rsp_data[INSTR_W-1 -: OPC_W])) halted_d = 1'b1;
            end
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            inflight_pc_q <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_pc_q <= inflight_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            halted_q      <= halted_d;
        end
    end

    // Decode-side outputs: head entry, or the bypassed response, else zero.
    always_comb begin
        instr_valid = queue_nonempty | bypass;
        instr       = '0;
        instr_pc    = '0;
        if (bypass) begin
            instr    = rsp_data;
            instr_pc = inflight_pc_q;
        end else if (queue_nonempty) begin
            instr    = head.instr;
            instr_pc = head.pc;
        end
    end

    assign fetch_halted = halted_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a table of cycle vectors with literal
// expectations, hand-written corner sequences and a randomized run, the
// latter two checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, rsp_valid;
    logic [15:0] req_addr, rsp_data, instr, instr_pc, redirect_pc;
    logic        instr_valid, instr_ready, redirect, fetch_halted;

    always #5 clk = ~clk;

    fetch_queue #(
        .INSTR_W (16), .ADDR_W (16), .DEPTH (DEPTH), .RESET_PC (RESET_PC), .PC_STEP (2)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
        .rsp_valid (rsp_valid), .rsp_data (rsp_data),
        .instr_valid (instr_valid), .instr_ready (instr_ready),
        .instr (instr), .instr_pc (instr_pc),
        .redirect (redirect), .redirect_pc (redirect_pc),
        .fetch_halted (fetch_halted)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic        rst, rdy, rv;
        logic [15:0] rd;
        logic        ir, rdr;
        logic [15:0] rpc;
        logic        chk, e_rv;
        logic [15:0] e_addr;
        logic        e_iv;
        logic [15:0] e_instr, e_pc;
        logic        e_h;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [15:0] rd,
                                input logic ir, input logic rdr, input logic [15:0] rpc,
                                input logic chk, input logic e_rv, input logic [15:0] e_addr,
                                input logic e_iv, input logic [15:0] e_instr, input logic [15:0] e_pc,
                                input logic e_h);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir; v.rdr = rdr; v.rpc = rpc;
        v.chk = chk; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_h = e_h;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic [15:0] mq_instr[$];
    logic [15:0] mq_pc[$];
    logic [15:0] m_fpc, m_inflight;
    bit          m_out, m_drop, m_halt;

    // Memory responder: one pending response, latency 1..lat_max cycles.
    bit          mem_pend;
    int          mem_cnt;
    logic [15:0] mem_data;
    int          lat_max   = 1;
    int          halt_addr = -1;
    bit          halt_rand = 1'b0;

    function automatic logic [15:0] mem_gen(input logic [15:0] addr);
        if (int'(addr) == halt_addr) return 16'hF000;
        if (halt_rand && $urandom_range(11, 0) == 0) return {4'hF, addr[11:0]};
        return 16'h1000 + addr;
    endfunction

    task automatic apply_mem();
        rsp_valid = mem_pend && (mem_cnt == 0);
        rsp_data  = rsp_valid ? mem_data : 16'h0000;
    endtask

    // One clock: drive memory, compare DUT outputs with the model, then
    // advance model and memory at the rising edge.
    task automatic model_cycle();
        bit          byp, acc, e_rv, e_iv;
        logic [15:0] e_instr, e_pc, fpc_before;
        apply_mem();
        @(negedge clk);
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = !rst && mq_pc.size() == 0 && rsp_valid && m_out && !m_drop && !redirect;
`endif
        e_rv    = !rst && !redirect && !m_halt && !m_out && (mq_pc.size() < DEPTH);
        e_iv    = (mq_pc.size() != 0) || byp;
        e_instr = byp ? rsp_data : (mq_pc.size() != 0 ? mq_instr[0] : 16'h0000);
        e_pc    = byp ? m_inflight : (mq_pc.size() != 0 ? mq_pc[0] : 16'h0000);
        check("m_req_valid", req_valid, e_rv);
        if (!rst) begin
            check("m_req_addr", req_addr, m_fpc);
            check("m_instr_valid", instr_valid, e_iv);
            check("m_instr", instr, e_instr);
            check("m_instr_pc", instr_pc, e_pc);
            check("m_fetch_halted", fetch_halted, m_halt);
        end
        acc        = e_rv && req_ready;
        fpc_before = m_fpc;
        @(posedge clk);
        if (rst) begin
            mq_instr.delete(); mq_pc.delete();
            m_fpc = RESET_PC; m_out = 0; m_drop = 0; m_halt = 0;
        end else if (redirect) begin
            mq_instr.delete(); mq_pc.delete();
            m_fpc  = redirect_pc;
            m_halt = 0;
            if (m_out) begin
                if (rsp_valid) begin m_out = 0; m_drop = 0; end
                else m_drop = 1;
            end
        end else begin
            if (mq_pc.size() != 0 && instr_ready) begin
                void'(mq_instr.pop_front()); void'(mq_pc.pop_front());
            end
            if (rsp_valid && m_out) begin
                m_out = 0;
                if (m_drop) m_drop = 0;
                else begin
                    if (rsp_data[15:12] == 4'hF) m_halt = 1;
                    if (!(byp && instr_ready)) begin
                        mq_instr.push_back(rsp_data); mq_pc.push_back(m_inflight);
                    end
                end
            end
            if (acc) begin
                m_out = 1; m_inflight = m_fpc; m_fpc = m_fpc + 16'd2;
            end
        end
        if (rsp_valid) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (rst) mem_pend = 0;
        if (acc) begin
            mem_pend = 1;
            mem_cnt  = $urandom_range(lat_max - 1, 0);
            mem_data = mem_gen(fpc_before);
        end
        #1;
    endtask

    task automatic reset_seq();
        rst = 1; redirect = 0; redirect_pc = 0; req_ready = 0; instr_ready = 0;
        model_cycle();
        model_cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1; req_ready = 0; rsp_valid = 0; rsp_data = 0;
        instr_ready = 0; redirect = 0; redirect_pc = 0;
        mem_pend = 0; mem_cnt = 0; mem_data = 0;
        @(posedge clk); #1;

`ifndef FETCH_BYPASS_EN
        //            rst rdy rv rd       ir rdr rpc       chk rv addr      iv instr    pc       h
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 1, 16'h1000, 1, 0, 16'h0000, 1, 0, 16'h0002, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'h1000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 1, 16'h1002, 1, 0, 16'h0000, 1, 0, 16'h0004, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'h1002, 16'h0002, 0));
        vecs.push_back(mk(0, 0, 1, 16'h1004, 0, 0, 16'h0000, 1, 0, 16'h0006, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0006, 1, 16'h1004, 16'h0004, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0006, 1, 16'h1004, 16'h0004, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0040, 1, 0, 16'h0008, 1, 16'h1004, 16'h0004, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0040, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 1, 16'h1006, 1, 0, 16'h0000, 1, 0, 16'h0040, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 1, 16'hF000, 0, 0, 16'h0000, 1, 0, 16'h0042, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0042, 1, 16'hF000, 16'h0040, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0042, 1, 16'hF000, 16'h0040, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0042, 0, 16'h0000, 16'h0000, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 16'hFFFE, 1, 0, 16'h0042, 0, 16'h0000, 16'h0000, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 1, 16'h1234, 1, 1, 16'h0010, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0010, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 1, 16'h2000, 0, 0, 16'h0000, 1, 0, 16'h0012, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0012, 1, 16'h2000, 16'h0010, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; req_ready = vecs[i].rdy; rsp_valid = vecs[i].rv; rsp_data = vecs[i].rd;
            instr_ready = vecs[i].ir; redirect = vecs[i].rdr; redirect_pc = vecs[i].rpc;
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("v%0d_req_valid", i), req_valid, vecs[i].e_rv);
                check($sformatf("v%0d_req_addr", i), req_addr, vecs[i].e_addr);
                check($sformatf("v%0d_instr_valid", i), instr_valid, vecs[i].e_iv);
                check($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
                check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].e_pc);
                check($sformatf("v%0d_fetch_halted", i), fetch_halted, vecs[i].e_h);
            end
            @(posedge clk); #1;
        end
        rsp_valid = 0;
`endif

        // Fill with decode stalled: four entries, then no more requests.
        lat_max = 1; halt_addr = -1; halt_rand = 0;
        reset_seq();
        req_ready = 1; instr_ready = 0;
        repeat (12) model_cycle();
        apply_mem(); #1;
        check("fill_no_req", req_valid, 1'b0);
        check("fill_head_pc", instr_pc, 16'h0000);
        instr_ready = 1;
        model_cycle();
        instr_ready = 0;
        apply_mem(); #1;
        check("refill_req_valid", req_valid, 1'b1);
        check("refill_req_addr", req_addr, 16'h0008);
        repeat (4) model_cycle();
        instr_ready = 1;
        repeat (6) model_cycle();

        // Halt opcode at pc 6, then redirect clears it and fetching resumes.
        halt_addr = 6;
        reset_seq();
        req_ready = 1; instr_ready = 1;
        repeat (12) model_cycle();
        apply_mem(); #1;
        check("halt_flag", fetch_halted, 1'b1);
        check("halt_no_req", req_valid, 1'b0);
        halt_addr = -1;
        redirect = 1; redirect_pc = 16'h0000;
        model_cycle();
        redirect = 0;
        apply_mem(); #1;
        check("halt_cleared", fetch_halted, 1'b0);
        check("resume_req_valid", req_valid, 1'b1);
        check("resume_req_addr", req_addr, 16'h0000);
        repeat (6) model_cycle();

        // Redirect coinciding with a response while two entries are queued.
        reset_seq();
        req_ready = 1; instr_ready = 0;
        repeat (5) model_cycle();
        redirect = 1; redirect_pc = 16'h0080;
        apply_mem(); #1;
        check("pre_redir_head_valid", instr_valid, 1'b1);
        check("pre_redir_head_pc", instr_pc, 16'h0000);
        model_cycle();
        redirect = 0;
        apply_mem(); #1;
        check("redir_flushed", instr_valid, 1'b0);
        check("redir_req_valid", req_valid, 1'b1);
        check("redir_req_addr", req_addr, 16'h0080);
        repeat (6) model_cycle();

        // Randomized traffic against the model.
        lat_max = 3; halt_rand = 1;
        reset_seq();
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(199, 0) == 0);
            req_ready   = ($urandom_range(3, 0) != 0);
            instr_ready = ($urandom_range(9, 0) < 7);
            redirect    = ($urandom_range(24, 0) == 0);
            redirect_pc = ($urandom_range(3, 0) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
            model_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
